waveform_renderer: RTL and testbench
====================================

# waveform_renderer

Multi-channel successor to `sample_to_pixel`. Pops one FIFO word per screen column carrying one signed sample per channel. Clears that column in the 1-bit framebuffer, then plots each channel inside its own horizontal band as a dot or as a vertical span joined to the previous column. Sits between the sample FIFO and `framebuffer`, and drives its write port directly.

## Interface
- `SCREEN_WIDTH`, 640: columns per frame.
- `SCREEN_HEIGHT`, 480: rows; must be divisible by `NUM_CHANNELS`.
- `NUM_CHANNELS`, 2: channels per FIFO word, 1..4.
- `DATA_WIDTH`, 32: bits per channel slot in the FIFO word.
- `SAMPLE_WIDTH`, 24: significant signed bits, in slot bits [SAMPLE_WIDTH-1:0].
- `ADDR_WIDTH`, $clog2(SCREEN_WIDTH*SCREEN_HEIGHT): pixel address width.
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `samples` in NUM_CHANNELS*DATA_WIDTH: channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH]. Show-ahead: valid while `fifo_almost_empty`=0.
- `fifo_almost_empty` in 1: high means no word is available.
- `mode` in 1: 0 = dot, 1 = connected line.
- `fifo_rd_en` out 1: one-cycle pop strobe.
- `pixel_addr` out ADDR_WIDTH: y*SCREEN_WIDTH + x.
- `pixel_data` out 1: 0 when clearing, 1 when drawing.
- `pixel_wr_en` out 1: write strobe.
- `frame_done` out 1: one-cycle pulse after the last column's final write.

## Operation
- Band geometry:
  - BAND = SCREEN_HEIGHT/NUM_CHANNELS, HALF = BAND/2.
  - centre_c = c*BAND + HALF.
- Per-channel row mapping:
  - s = signed `samples` slot c, bits [SAMPLE_WIDTH-1:0].
  - off = (s*HALF) >>> (SAMPLE_WIDTH-1), arithmetic shift; the product is signed and SAMPLE_WIDTH+$clog2(HALF)+1 bits wide.
  - y_c = centre_c − off, clamped to [c*BAND, c*BAND+BAND−1].
- States:
  - IDLE: entered after reset; goes to FETCH next cycle.
  - FETCH: waits while `fifo_almost_empty`=1. Otherwise asserts `fifo_rd_en` for exactly one cycle, captures all slots and `mode` in that same cycle, then goes to CLEAR.
  - CLEAR: writes 0 at rows 0..SCREEN_HEIGHT−1 of column x, one row per cycle, then goes to CALC with c=0.
  - CALC: registers y_c. Span is lo = min(prev_y_c, y_c), hi = max(prev_y_c, y_c) in line mode with x>0; otherwise lo = hi = y_c. Then goes to DRAW.
  - DRAW: writes 1 at rows lo..hi, one row per cycle. At the end it sets prev_y_c = y_c, then goes to CALC with c+1, or to NEXT after the last channel.
  - NEXT: if x = SCREEN_WIDTH−1, sets x=0 and pulses `frame_done`; otherwise x+1. Then goes to FETCH.
- `prev_y` is updated in both modes, so switching dot→line mid-frame joins correctly at the next column.
- `mode` is sampled only in FETCH; a change mid-column has no effect until the next column.
- Channels are drawn in ascending c. Bands never overlap, so channels do not overwrite each other.

## Timing
- Reset values:
  - All outputs 0.
  - x=0, c=0, all `prev_y` = centre_c, state IDLE.
- Reset asserted mid-column: writes stop on the following edge, and the partial column is not completed.
- Pop-to-write latency: the first CLEAR write (row 0) is on the cycle after the `fifo_rd_en` cycle.
- Strobes:
  - `fifo_rd_en` is never asserted while `fifo_almost_empty`=1, and never twice within one column.
  - `pixel_wr_en` is high every cycle of CLEAR and DRAW, and low in all other states.
- Column length: 1 (FETCH, no stall) + SCREEN_HEIGHT + Σc(1 + hi_c − lo_c + 1) + 1 (NEXT) cycles.
- `frame_done` is high during the NEXT cycle of column SCREEN_WIDTH−1. The next FETCH starts column 0 with no extra gap.
- A FIFO stall only lengthens FETCH; nothing else changes.

## Test plan
- Reset check:
  - Stimulus: hold `resetn`=0 for 3 cycles, then release with `fifo_almost_empty`=1.
  - Response: all outputs 0 throughout, and no `fifo_rd_en` or `pixel_wr_en` for 100 cycles.
- Dot, zero sample:
  - Stimulus: NUM_CHANNELS=1, mode 0, push 640 words of 0.
  - Response: each column x holds a 1 only at row 240 (address 240*640+x), and `frame_done` pulses exactly once.
- Clamp, full scale:
  - Stimulus: NUM_CHANNELS=2 (BAND=240, HALF=120); ch0 = 0x7FFFFF, ch1 = 0x800000.
  - Response: ch0 at row 1 (0+120−119); ch1 at row 479 (360+120 clamped to 479).
- Line span:
  - Stimulus: NUM_CHANNELS=1, mode 1, column 0 off=+100, column 1 off=−50.
  - Response: column 0 is a single dot at row 140; column 1 is rows 140..290 all 1, i.e. 151 DRAW writes.
- FIFO stall:
  - Stimulus: deassert `fifo_almost_empty` for 1 cycle, then hold it high 50 cycles mid-frame.
  - Response: exactly one `fifo_rd_en` pulse; the block sits in FETCH with no writes; it resumes one cycle after the flag drops.
- Mode switch and wrap:
  - Stimulus: switch mode 0→1 during column 5's CLEAR.
  - Response: column 5 is still dots, and column 6 joins to column 5's y. After column 639, x returns to 0 and column 0 is drawn as a dot.

Source files
------------

// File: rtl/waveform_renderer_if.sv
// rtl/waveform_renderer_if.sv - sample FIFO read side and framebuffer write port of the renderer
interface waveform_renderer_if #(
    parameter int NUM_CHANNELS = 2,
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 19
);
    logic [NUM_CHANNELS*DATA_WIDTH-1:0] samples;
    logic                               fifo_almost_empty;
    logic                               fifo_rd_en;
    logic [ADDR_WIDTH-1:0]              pixel_addr;
    logic                               pixel_data;
    logic                               pixel_wr_en;

    modport master (
        input  samples, fifo_almost_empty,
        output fifo_rd_en, pixel_addr, pixel_data, pixel_wr_en
    );

    modport slave (
        output samples, fifo_almost_empty,
        input  fifo_rd_en, pixel_addr, pixel_data, pixel_wr_en
    );
endinterface

// File: rtl/waveform_renderer.sv
// rtl/waveform_renderer.sv - per-column clear and multi-channel dot/line plotting into a 1-bit framebuffer
module waveform_renderer #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int NUM_CHANNELS  = 2,
    parameter int DATA_WIDTH    = 32,
    parameter int SAMPLE_WIDTH  = 24,
    parameter int ADDR_WIDTH    = $clog2(SCREEN_WIDTH*SCREEN_HEIGHT)
) (
    input  logic clk,
    input  logic resetn,
    input  logic mode,
    output logic frame_done,
    waveform_renderer_if.master bus
);
    localparam int BAND = SCREEN_HEIGHT / NUM_CHANNELS;
    localparam int HALF = BAND / 2;
    localparam int XW   = (SCREEN_WIDTH > 1)  ? $clog2(SCREEN_WIDTH)  : 1;
    localparam int YW   = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
    localparam int CW   = (NUM_CHANNELS > 1)  ? $clog2(NUM_CHANNELS)  : 1;
    localparam int PW   = SAMPLE_WIDTH + $clog2(HALF) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CLEAR,
        S_CALC,
        S_DRAW,
        S_NEXT
    } state_t;

    state_t                  state, state_next;
    logic [XW-1:0]           x;
    logic [YW-1:0]           row;
    logic [YW-1:0]           hi_q;
    logic [YW-1:0]           y_q;
    logic [CW-1:0]           c;
    logic                    mode_q;
    logic [SAMPLE_WIDTH-1:0] slot_q [NUM_CHANNELS];
    logic [YW-1:0]           prev_y [NUM_CHANNELS];

    logic last_row, last_chan, last_col, draw_end;

    assign last_row  = (row == YW'(SCREEN_HEIGHT - 1));
    assign last_chan = (c == CW'(NUM_CHANNELS - 1));
    assign last_col  = (x == XW'(SCREEN_WIDTH - 1));
    assign draw_end  = (row == hi_q);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = S_FETCH;
            S_FETCH: if (!bus.fifo_almost_empty) state_next = S_CLEAR;
            S_CLEAR: if (last_row) state_next = S_CALC;
            S_CALC:  state_next = S_DRAW;
            S_DRAW:  if (draw_end) state_next = last_chan ? S_NEXT : S_CALC;
            S_NEXT:  state_next = S_FETCH;
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.fifo_rd_en  = (state == S_FETCH) && !bus.fifo_almost_empty;
    assign bus.pixel_wr_en = (state == S_CLEAR) || (state == S_DRAW);
    assign bus.pixel_data  = (state == S_DRAW);
    assign bus.pixel_addr  = bus.pixel_wr_en
                           ? ADDR_WIDTH'(row) * ADDR_WIDTH'(SCREEN_WIDTH) + ADDR_WIDTH'(x)
                           : '0;
    assign frame_done      = (state == S_NEXT) && last_col;

    // Sample-to-row mapping for the channel currently selected by c.
    logic signed [SAMPLE_WIDTH-1:0] s_cur;
    logic signed [PW-1:0]           prod;
    logic signed [PW-1:0]           off;
    int                             band_lo;
    longint                         y_raw;
    logic [YW-1:0]                  y_calc, lo_calc, hi_calc, prev_cur;

    always_comb begin
        s_cur   = slot_q[c];
        prod    = $signed(PW'(s_cur)) * $signed(PW'(HALF));
        off     = prod >>> (SAMPLE_WIDTH - 1);
        band_lo = int'(c) * BAND;
        y_raw   = longint'(band_lo + HALF) - longint'(off);
        if (y_raw < longint'(band_lo)) begin
            y_calc = YW'(band_lo);
        end else if (y_raw > longint'(band_lo + BAND - 1)) begin
            y_calc = YW'(band_lo + BAND - 1);
        end else begin
            y_calc = YW'(y_raw);
        end
        prev_cur = prev_y[c];
        lo_calc  = y_calc;
        hi_calc  = y_calc;
        // Column 0 never joins: the previous column belongs to the prior frame.
        if (mode_q && (x != '0)) begin
            if (prev_cur < y_calc) begin
                lo_calc = prev_cur;
            end else begin
                hi_calc = prev_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x      <= '0;
            row    <= '0;
            c      <= '0;
            hi_q   <= '0;
            y_q    <= '0;
            mode_q <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                slot_q[i] <= '0;
                prev_y[i] <= YW'(i * BAND + HALF);
            end
        end else begin
            case (state)
                S_FETCH: begin
                    if (!bus.fifo_almost_empty) begin
                        for (int i = 0; i < NUM_CHANNELS; i++) begin
                            slot_q[i] <= bus.samples[i*DATA_WIDTH +: SAMPLE_WIDTH];
                        end
                        mode_q <= mode;
                        row    <= '0;
                    end
                end
                S_CLEAR: begin
                    if (last_row) begin
                        c <= '0;
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                S_CALC: begin
                    y_q  <= y_calc;
                    row  <= lo_calc;
                    hi_q <= hi_calc;
                end
                S_DRAW: begin
                    if (draw_end) begin
                        prev_y[c] <= y_q;
                        if (!last_chan) begin
                            c <= c + 1'b1;
                        end
                    end else begin
                        row <= row + 1'b1;
                    end
                end
                S_NEXT: begin
                    x   <= last_col ? '0 : x + 1'b1;
                    row <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_waveform_renderer.sv
// tb/tb_waveform_renderer.sv - scoreboard bench for waveform_renderer on a narrow 8-column screen
module tb_waveform_renderer;
    localparam int W    = 8;
    localparam int H    = 480;
    localparam int NC   = 2;
    localparam int DW   = 32;
    localparam int SW   = 24;
    localparam int AW   = $clog2(W*H);
    localparam int BAND = H / NC;
    localparam int HALF = BAND / 2;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          data;
    } wr_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic mode = 1'b0;
    logic frame_done;

    always #5 clk = ~clk;

    waveform_renderer_if #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

    waveform_renderer #(
        .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .NUM_CHANNELS(NC),
        .DATA_WIDTH(DW), .SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .mode(mode),
        .frame_done(frame_done),
        .bus(bus)
    );

    wr_t              wq[$];
    logic [NC*DW-1:0] fifo_q[$];
    logic [NC*DW-1:0] dummy;
    logic             pop_pending = 1'b0;
    logic             fb [W*H];
    int checks = 0, errors = 0, cyc = 0;
    int rd_count = 0, wr_count = 0, fd_count = 0;
    int rd_cyc = 0, first_lat = -1;
    bit lat_armed = 0;
    int rd_stamps[$];
    int len_q[$];
    int mx = 0, last_col_x = -1;
    int mprev[NC];

    function automatic logic [NC*DW-1:0] mk(input logic [DW-1:0] ch0, input logic [DW-1:0] ch1);
        return {ch1, ch0};
    endfunction

    function automatic int col_ones(input int x, input int r0, input int r1);
        int n = 0;
        for (int r = r0; r <= r1; r++) if (fb[r*W+x] === 1'b1) n++;
        return n;
    endfunction

    // Expected write stream for one popped word, from the band/offset/clamp/span rules.
    task automatic model_column(input logic [NC*DW-1:0] word, input logic m);
        wr_t e;
        int  len;
        len = 2 + H;
        for (int r = 0; r < H; r++) begin
            e.addr = AW'(r*W + mx); e.data = 1'b0; wq.push_back(e);
        end
        for (int ch = 0; ch < NC; ch++) begin
            longint sv, off;
            int y, lo, hi, blo;
            sv  = longint'($signed(word[ch*DW +: SW]));
            off = (sv * longint'(HALF)) >>> (SW-1);
            blo = ch * BAND;
            y   = int'(longint'(blo + HALF) - off);
            if (y < blo) y = blo;
            if (y > blo + BAND - 1) y = blo + BAND - 1;
            lo = y; hi = y;
            if (m && mx != 0) begin
                lo = (mprev[ch] < y) ? mprev[ch] : y;
                hi = (mprev[ch] < y) ? y : mprev[ch];
            end
            for (int r = lo; r <= hi; r++) begin
                e.addr = AW'(r*W + mx); e.data = 1'b1; wq.push_back(e);
            end
            len += 2 + hi - lo;
            mprev[ch] = y;
        end
        len_q.push_back(len);
        last_col_x = mx;
        mx = (mx == W-1) ? 0 : mx + 1;
    endtask

    always @(posedge clk) begin
        #1;
        if (pop_pending) begin
            dummy = fifo_q.pop_front();
            pop_pending = 1'b0;
        end
        bus.fifo_almost_empty = (fifo_q.size() == 0);
        bus.samples = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    end

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (resetn) begin
            if (bus.fifo_rd_en) begin
                checks++;
                if (bus.fifo_almost_empty !== 1'b0 || fifo_q.size() == 0) begin
                    errors++;
                    $display("FAIL rd_when_empty: almost_empty=%0b words=%0d, required 0 and >0", bus.fifo_almost_empty, fifo_q.size());
                end
                checks++;
                if (wq.size() != 0) begin
                    errors++;
                    $display("FAIL rd_mid_column: %0d writes outstanding, required 0", wq.size());
                end
                model_column(bus.samples, mode);
                pop_pending = 1'b1;
                rd_count++;
                rd_cyc = cyc;
                lat_armed = 1;
                rd_stamps.push_back(cyc);
            end
            if (bus.pixel_wr_en) begin
                wr_count++;
                if (lat_armed) begin
                    first_lat = cyc - rd_cyc;
                    lat_armed = 0;
                end
                checks++;
                if (wq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%0d data=%0b, required no write", bus.pixel_addr, bus.pixel_data);
                end else begin
                    e = wq.pop_front();
                    if (bus.pixel_addr !== e.addr || bus.pixel_data !== e.data) begin
                        errors++;
                        $display("FAIL write: addr=%0d data=%0b, required addr=%0d data=%0b", bus.pixel_addr, bus.pixel_data, e.addr, e.data);
                    end
                end
                if (!$isunknown(bus.pixel_addr) && int'(bus.pixel_addr) < W*H) fb[bus.pixel_addr] = bus.pixel_data;
            end
            if (frame_done) begin
                fd_count++;
                checks++;
                if (wq.size() != 0 || last_col_x != W-1) begin
                    errors++;
                    $display("FAIL frame_done_timing: pending=%0d column=%0d, required 0 and %0d", wq.size(), last_col_x, W-1);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((fifo_q.size() != 0 || wq.size() != 0 || pop_pending) && n < 20000) begin
            @(posedge clk);
            n++;
        end
        tick(3);
        checks++;
        if (n >= 20000) begin
            errors++;
            $display("FAIL %s_timeout: %0d writes and %0d words pending, required 0", tag, wq.size(), fifo_q.size());
        end
    endtask

    task automatic test_reset();
        int rd0, wr0;
        resetn = 1'b0;
        mode = 1'b0;
        bus.fifo_almost_empty = 1'b1;
        bus.samples = '0;
        mx = 0;
        for (int ch = 0; ch < NC; ch++) mprev[ch] = ch*BAND + HALF;
        for (int i = 0; i < W*H; i++) fb[i] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({bus.fifo_rd_en, bus.pixel_wr_en, bus.pixel_data, frame_done} !== 4'b0 || bus.pixel_addr !== '0) begin
                errors++;
                $display("FAIL reset_outputs: rd=%0b wr=%0b data=%0b fd=%0b addr=%0d, required all 0",
                         bus.fifo_rd_en, bus.pixel_wr_en, bus.pixel_data, frame_done, bus.pixel_addr);
            end
        end
        tick(1);
        resetn = 1'b1;
        rd0 = rd_count;
        wr0 = wr_count;
        tick(100);
        checks++;
        if (rd_count != rd0 || wr_count != wr0) begin
            errors++;
            $display("FAIL reset_idle: rd=%0d wr=%0d strobes, required 0 and 0", rd_count - rd0, wr_count - wr0);
        end
        checks++;
        if ({bus.fifo_rd_en, bus.pixel_wr_en, bus.pixel_data, frame_done} !== 4'b0 || bus.pixel_addr !== '0) begin
            errors++;
            $display("FAIL idle_outputs: rd=%0b wr=%0b addr=%0d, required all 0", bus.fifo_rd_en, bus.pixel_wr_en, bus.pixel_addr);
        end
    endtask

    task automatic test_dot_zero();
        int fd0 = fd_count;
        mode = 1'b0;
        for (int i = 0; i < W; i++) fifo_q.push_back(mk(32'h0, 32'h0));
        wait_idle("dot_zero");
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++;
            $display("FAIL dot_frame_done: %0d pulses, required 1", fd_count - fd0);
        end
        for (int x = 0; x < W; x++) begin
            checks++;
            if (col_ones(x, 0, H-1) != 2 || fb[120*W+x] !== 1'b1 || fb[360*W+x] !== 1'b1) begin
                errors++;
                $display("FAIL dot_column_%0d: ones=%0d r120=%0b r360=%0b, required 2,1,1", x, col_ones(x, 0, H-1), fb[120*W+x], fb[360*W+x]);
            end
        end
    endtask

    task automatic test_line_span();
        mode = 1'b1;
        fifo_q.push_back(mk(32'h5A6AAAAB, 32'h0));
        fifo_q.push_back(mk(32'h33CAAAAB, 32'h0));
        wait_idle("line_span");
        checks++;
        if (col_ones(0, 0, BAND-1) != 1 || fb[20*W+0] !== 1'b1) begin
            errors++;
            $display("FAIL line_col0: ones=%0d r20=%0b, required 1 and 1", col_ones(0, 0, BAND-1), fb[20*W]);
        end
        checks++;
        if (col_ones(1, 0, BAND-1) != 151 || col_ones(1, 20, 170) != 151) begin
            errors++;
            $display("FAIL line_col1: ones=%0d in_span=%0d, required 151 and 151", col_ones(1, 0, BAND-1), col_ones(1, 20, 170));
        end
        checks++;
        if (col_ones(1, BAND, H-1) != 1 || fb[360*W+1] !== 1'b1) begin
            errors++;
            $display("FAIL line_ch1: ones=%0d r360=%0b, required 1 and 1", col_ones(1, BAND, H-1), fb[360*W+1]);
        end
    endtask

    task automatic test_clamp();
        mode = 1'b0;
        fifo_q.push_back(mk(32'hFF7FFFFF, 32'h00800000));
        wait_idle("clamp");
        checks++;
        if (fb[1*W+2] !== 1'b1 || fb[479*W+2] !== 1'b1 || col_ones(2, 0, H-1) != 2) begin
            errors++;
            $display("FAIL clamp: r1=%0b r479=%0b ones=%0d, required 1,1,2", fb[W+2], fb[479*W+2], col_ones(2, 0, H-1));
        end
    endtask

    task automatic test_fifo_stall();
        int rd0, wr0;
        rd0 = rd_count;
        wr0 = wr_count;
        tick(50);
        checks++;
        if (rd_count != rd0 || wr_count != wr0) begin
            errors++;
            $display("FAIL stall_idle: rd=%0d wr=%0d, required 0 and 0", rd_count - rd0, wr_count - wr0);
        end
        first_lat = -1;
        fifo_q.push_back(mk(32'h00100000, 32'h00F00000));
        wait_idle("stall_resume");
        wr0 = wr_count;
        tick(50);
        checks++;
        if (rd_count - rd0 != 1) begin
            errors++;
            $display("FAIL stall_pops: %0d pulses, required 1", rd_count - rd0);
        end
        checks++;
        if (first_lat != 1) begin
            errors++;
            $display("FAIL pop_to_write: latency=%0d, required 1", first_lat);
        end
        checks++;
        if (wr_count != wr0) begin
            errors++;
            $display("FAIL stall_writes: %0d, required 0", wr_count - wr0);
        end
    endtask

    task automatic test_mode_wrap();
        int rd0, fd0, n;
        mode = 1'b0;
        n = 0;
        while (mx != 5 && n < 2*W) begin
            fifo_q.push_back(mk(32'h0, 32'h0));
            wait_idle("mode_align");
            n++;
        end
        fd0 = fd_count;
        rd0 = rd_count;
        fifo_q.push_back(mk(32'h00400000, 32'h00E00000));
        n = 0;
        while (rd_count == rd0 && n < 100) begin
            tick(1);
            n++;
        end
        tick(10);
        mode = 1'b1;
        fifo_q.push_back(mk(32'h00C00000, 32'h00200000));
        fifo_q.push_back(mk(32'h0, 32'h0));
        fifo_q.push_back(mk(32'h0, 32'h0));
        wait_idle("mode_wrap");
        checks++;
        if (col_ones(5, 0, H-1) != 2 || fb[60*W+5] !== 1'b1 || fb[390*W+5] !== 1'b1) begin
            errors++;
            $display("FAIL mode_col5_dot: ones=%0d r60=%0b r390=%0b, required 2,1,1", col_ones(5, 0, H-1), fb[60*W+5], fb[390*W+5]);
        end
        checks++;
        if (col_ones(6, 0, BAND-1) != 121 || col_ones(6, 60, 180) != 121) begin
            errors++;
            $display("FAIL mode_col6_ch0: ones=%0d span=%0d, required 121 and 121", col_ones(6, 0, BAND-1), col_ones(6, 60, 180));
        end
        checks++;
        if (col_ones(6, BAND, H-1) != 61 || col_ones(6, 330, 390) != 61) begin
            errors++;
            $display("FAIL mode_col6_ch1: ones=%0d span=%0d, required 61 and 61", col_ones(6, BAND, H-1), col_ones(6, 330, 390));
        end
        checks++;
        if (col_ones(0, 0, H-1) != 2 || fb[120*W] !== 1'b1 || fb[360*W] !== 1'b1) begin
            errors++;
            $display("FAIL wrap_col0_dot: ones=%0d r120=%0b r360=%0b, required 2,1,1", col_ones(0, 0, H-1), fb[120*W], fb[360*W]);
        end
        checks++;
        if (fd_count - fd0 != 1) begin
            errors++;
            $display("FAIL wrap_frame_done: %0d pulses, required 1", fd_count - fd0);
        end
    endtask

    task automatic test_back_to_back();
        int s0, l0;
        mode = 1'b1;
        s0 = rd_stamps.size();
        l0 = len_q.size();
        fifo_q.push_back(mk(32'($urandom), 32'($urandom)));
        fifo_q.push_back(mk(32'($urandom), 32'($urandom)));
        wait_idle("back_to_back");
        checks++;
        if (rd_stamps.size() - s0 != 2) begin
            errors++;
            $display("FAIL b2b_pops: %0d, required 2", rd_stamps.size() - s0);
        end else begin
            checks++;
            if (rd_stamps[s0+1] - rd_stamps[s0] != len_q[l0]) begin
                errors++;
                $display("FAIL column_length: %0d cycles, required %0d", rd_stamps[s0+1] - rd_stamps[s0], len_q[l0]);
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dot_zero();
        test_line_span();
        test_clamp();
        test_fifo_stall();
        test_mode_wrap();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
